// File: rtl/reg_file_scoreboard.sv
// Multi-read register file with a per-register busy scoreboard.
// Two asynchronous read ports, one writeback port and a reserve/grant handshake
// that issue logic uses to track RAW/WAW hazards on destination registers.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding of
// writeback data and busy state to the read ports and the reserve grant.
module reg_file_scoreboard #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readOut1,
  output logic              readBusy1,
  output logic [DATA_W-1:0] readOut2,
  output logic              readBusy2,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] resvAddr,
  input  logic              resvEn,
  output logic              resvGnt,
  output logic              busyAny
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              busyAny_q;
  logic              wrValid;
  logic              resvBusy;

  // True for the hard-wired zero register when that option is enabled.
  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return R0_ZERO && (addr == '0);
  endfunction

  // A write to a zeroed r0 is dropped entirely, including its busy clear.
  assign wrValid = writeEn && !isZeroReg(writeAddr);

  // Read port 1: stored value, optionally forwarded from the writeback port.
  always_comb begin
    readOut1  = regs_q[readAddr1];
    readBusy1 = busy_q[readAddr1];
`ifdef REGFILE_BYPASS_EN
    if (wrValid && (readAddr1 == writeAddr)) begin
      readOut1  = dataIn;
      readBusy1 = 1'b0;
    end
`endif
    if (isZeroReg(readAddr1)) begin
      readOut1  = '0;
      readBusy1 = 1'b0;
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    readOut2  = regs_q[readAddr2];
    readBusy2 = busy_q[readAddr2];
`ifdef REGFILE_BYPASS_EN
    if (wrValid && (readAddr2 == writeAddr)) begin
      readOut2  = dataIn;
      readBusy2 = 1'b0;
    end
`endif
    if (isZeroReg(readAddr2)) begin
      readOut2  = '0;
      readBusy2 = 1'b0;
    end
  end

  // Reserve grant: denied while the destination is busy; with forwarding, a
  // same-cycle writeback to the destination counts as already cleared.
  always_comb begin
    resvBusy = busy_q[resvAddr];
`ifdef REGFILE_BYPASS_EN
    if (wrValid && (resvAddr == writeAddr)) begin
      resvBusy = 1'b0;
    end
`endif
    if (isZeroReg(resvAddr)) begin
      resvBusy = 1'b0;
    end
    resvGnt = resvEn && !resvBusy;
  end

  // Next busy vector: writeback clears first, then a granted reserve sets, so
  // a same-address write+reserve leaves the new producer marked busy.
  always_comb begin
    busy_d = busy_q;
    if (wrValid) begin
      busy_d[writeAddr] = 1'b0;
    end
    if (resvGnt && !isZeroReg(resvAddr)) begin
      busy_d[resvAddr] = 1'b1;
    end
  end

  // State update with synchronous reset overriding any write or reserve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      busyAny_q <= 1'b0;
    end else begin
      if (wrValid) begin
        regs_q[writeAddr] <= dataIn;
      end
      busy_q    <= busy_d;
      busyAny_q <= |busy_d;
    end
  end

  assign busyAny = busyAny_q;

endmodule
